// File: rtl/aes_key_expander.sv
// AES-128 key schedule. Holds only the current round key and derives the
// next one combinationally from it, handing keys 0..NROUNDS to the round
// controller over a valid/ready handshake.

// Forward S-box, one byte in, one byte out. The table is packed MSB-first,
// so entry a sits at bits [(255-a)*8+7 -: 8] == [{~a,3'b111} -: 8].
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b111} -: 8];
endmodule

module aes_key_expander #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipherkey,
  input  logic         keyready,
  output logic [127:0] roundkey,
  output logic [3:0]   roundnum,
  output logic         keyvalid,
  output logic         busy,
  output logic         done
);
  localparam logic [3:0] LAST = 4'(NROUNDS);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] nextkey;
  logic         accept, last;

  // Round constant for the key being produced (next round 1..10).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = roundkey;
  assign rot = {w3[23:0], w3[31:24]};

  // SubWord: one S-box per byte of the rotated word.
  for (genvar j = 0; j < 4; j++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot[31-8*j -: 8]),
      .y (sub[31-8*j -: 8])
    );
  end

  assign t  = sub ^ {rcon(roundnum + 4'd1), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign nextkey = {n0, n1, n2, n3};

  assign accept = (state == PRESENT) && keyready;
  assign last   = (roundnum == LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: leave IDLE on start, return once the final key is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)         state_nxt = PRESENT;
      PRESENT: if (accept && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: a key is on offer for the whole of PRESENT.
  always_comb begin
    keyvalid = (state == PRESENT);
    busy     = (state == PRESENT);
  end

  // Round key / index register; the cipher key is only sampled at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roundkey <= '0;
      roundnum <= '0;
    end else if (state == IDLE && start) begin
      roundkey <= cipherkey;
      roundnum <= '0;
    end else if (accept && !last) begin
      roundkey <= nextkey;
      roundnum <= roundnum + 4'd1;
    end
  end

  // Completion pulse, high for the cycle after the last key is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= accept && last;
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 A.1 and all-zero key.
module tb_aes_key_expander;
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipherkey;
  logic         keyready;
  logic [127:0] roundkey;
  logic [3:0]   roundnum;
  logic         keyvalid, busy, done;

  int errors = 0;
  int checks = 0;

  logic [127:0] fips [0:10];
  localparam logic [127:0] FKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expander #(.NROUNDS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cipherkey (cipherkey),
    .keyready  (keyready),
    .roundkey  (roundkey),
    .roundnum  (roundnum),
    .keyvalid  (keyvalid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with key 0 on display.
  task automatic do_start(input logic [127:0] k);
    cipherkey = k;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic chk_idle_after_last(input string tag);
    chk({tag, "_done"},  128'(done),     128'd1);
    chk({tag, "_valid"}, 128'(keyvalid), 128'd0);
    chk({tag, "_busy"},  128'(busy),     128'd0);
  endtask

  initial begin
    int idx;
    int cyc;
    fips[0]  = FKEY;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset = 1'b1; start = 1'b0; keyready = 1'b0; cipherkey = '0;
    #3;
    chk("rst_key",   roundkey,        128'd0);
    chk("rst_num",   128'(roundnum),  128'd0);
    chk("rst_valid", 128'(keyvalid),  128'd0);
    chk("rst_busy",  128'(busy),      128'd0);
    chk("rst_done",  128'(done),      128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_valid", 128'(keyvalid), 128'd0);
    chk("idle_busy",  128'(busy),     128'd0);

    // FIPS-197 vector, ready held high, with start/cipherkey pokes mid-run.
    keyready = 1'b1;
    do_start(FKEY);
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("fips_valid%0d", i), 128'(keyvalid), 128'd1);
      chk($sformatf("fips_num%0d", i),   128'(roundnum), 128'(i));
      chk($sformatf("fips_key%0d", i),   roundkey,       fips[i]);
      if (i == 3) begin start = 1'b1; cipherkey = '0; end
      if (i == 5) start = 1'b0;
      @(negedge clk);
    end
    chk_idle_after_last("fips_end");
    @(negedge clk);
    chk("fips_done_pulse", 128'(done), 128'd0);

    // Zero key; start again on the done cycle.
    do_start('0);
    chk("zero_key0", roundkey, 128'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) chk("zero_key1", roundkey, 128'h62636363626363636263636362636363);
      @(negedge clk);
    end
    chk("zero_num10", 128'(roundnum), 128'd10);
    chk("zero_key10", roundkey, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    @(negedge clk);
    chk_idle_after_last("zero_end");
    cipherkey = FKEY;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("donestart_valid", 128'(keyvalid), 128'd1);
    chk("donestart_num",   128'(roundnum), 128'd0);
    chk("donestart_key",   roundkey,       fips[0]);

    // Backpressure: random ready, sequence must match the table in order.
    idx = 0;
    cyc = 0;
    while (!done && cyc < 300) begin
      if (keyvalid) begin
        chk($sformatf("bp_num_c%0d", cyc), 128'(roundnum), 128'(idx));
        chk($sformatf("bp_key_c%0d", cyc), roundkey,       fips[idx]);
      end
      keyready = ($urandom_range(0, 2) != 0);
      if (keyvalid && keyready) idx++;
      @(negedge clk);
      cyc++;
    end
    chk("bp_timeout", 128'(done), 128'd1);
    chk("bp_count",   128'(idx),  128'd11);

    // Reset mid-sequence at round 5, then restart cleanly.
    keyready = 1'b1;
    @(negedge clk);
    do_start(FKEY);
    repeat (5) @(negedge clk);
    chk("mid_num5", 128'(roundnum), 128'd5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_key",   roundkey,       128'd0);
    chk("mid_rst_num",   128'(roundnum), 128'd0);
    chk("mid_rst_valid", 128'(keyvalid), 128'd0);
    chk("mid_rst_busy",  128'(busy),     128'd0);
    chk("mid_rst_done",  128'(done),     128'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 128'(keyvalid), 128'd0);
    do_start(FKEY);
    chk("restart_num0", 128'(roundnum), 128'd0);
    chk("restart_key0", roundkey,       fips[0]);
    @(negedge clk);
    chk("restart_key1", roundkey,       fips[1]);
    @(negedge clk);
    chk("restart_key2", roundkey,       fips[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- AES-128 key schedule generator; sits directly upstream of the add-round-key stage and supplies its round key operand.
- Loads a 128-bit cipher key on start, then emits round keys 0..10 in order, one per accepted handshake.
- Computes each key on the fly, so only the current round key is stored.
- The round controller consumes keys with a valid/ready handshake.

Parameters:
- NROUNDS, 10, index of the last round key (AES-128); keys 0..NROUNDS are emitted.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a new expansion; sampled only in IDLE
- cipherkey  input  128  key for round 0; byte 0 = bits [127:120], column-major per FIPS-197
- keyready  input  1  consumer accepts roundkey this cycle
- roundkey  output  128  current round key, same byte order as cipherkey
- roundnum  output  4  index of the current roundkey, 0..NROUNDS
- keyvalid  output  1  roundkey/roundnum valid
- busy  output  1  expansion in progress (state != IDLE)
- done  output  1  one-cycle pulse after key NROUNDS is accepted

Behaviour:
- Reset (async, any time, including mid-sequence) forces these values immediately:
  - state = IDLE
  - roundkey = 0, roundnum = 0
  - keyvalid = 0, busy = 0, done = 0
- States: IDLE, PRESENT.
- IDLE, start = 1 at edge N:
  - roundkey <= cipherkey, roundnum <= 0, keyvalid <= 1, busy <= 1, state <= PRESENT.
  - Key 0 is visible in the cycle after edge N (latency 1).
- PRESENT, keyready = 0: roundkey, roundnum and keyvalid hold stable.
- PRESENT, keyready = 1, roundnum < NROUNDS:
  - roundkey <= next key; roundnum <= roundnum + 1; keyvalid stays 1.
  - With keyready held high, one key is emitted per cycle and all 11 keys take 11 cycles.
- PRESENT, keyready = 1, roundnum == NROUNDS:
  - keyvalid <= 0, busy <= 0, done <= 1 for exactly one cycle, state <= IDLE.
- start while busy is ignored. cipherkey is sampled only at start, so later changes have no effect on a running expansion.
- start asserted in the same cycle done is high is accepted, because the state is IDLE by then.
- Next-key function, with previous key as words w0..w3 (w0 = bits [127:96]):
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
  - RotWord: byte rotate left by one.
  - SubWord: FIPS-197 forward S-box on each of 4 bytes (4 combinational S-box instances).
- rcon indexed by next round 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36; GF(2^8) byte arithmetic, no carries beyond 8 bits.
- The next-key path is purely combinational from the roundkey register: one register stage, no multicycle paths.
- roundnum never exceeds NROUNDS and does not wrap.

Test Plan:
- Reset check: assert reset mid-cycle with no clock edge -> all outputs 0 immediately; start held low -> keyvalid stays 0.
- FIPS-197 vector, keyready held high: cipherkey = 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> expected keys:
  - roundnum 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - roundnum 1 = a0fafe1788542cb123a339392a6c7605
  - roundnum 2 = f2c295f27a96b9435935807a7359f67f
  - roundnum 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses exactly one cycle after key 10; 11 consecutive valid cycles.
- Zero key: cipherkey = 0 -> key 1 = 62636363626363636263636362636363, key 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: toggle keyready randomly -> roundkey/roundnum stable while keyvalid && !keyready; the sequence matches the ready-high run, with no skipped or repeated round.
- start and cipherkey changes while busy (e.g. 0 at roundnum 3) -> ignored; the FIPS sequence completes unchanged.
- Reset at roundnum 5 -> outputs cleared immediately; a following start restarts from key 0 with correct values.
